bcd_to_bin_serial: RTL and testbench

//  Serial BCD-to-binary converter using reverse double-dabble: each cycle

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_to_bin_serial.sv | 117 +++++++++++
 tb/tb_bcd_to_bin_serial.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD<->binary converters: digit width,
// converter FSM states and a digit legality helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: a digit that
// reached 8 or more after the right shift is pulled back by 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter (reverse double-dabble), one bit per cycle.
// Optional input digit check is enabled with the BCD_DIGIT_CHECK_EN macro.
module bcd_to_bin_serial
    import bcd_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NDIG-1:0]       bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    err
);

    localparam int BCD_W = DIGIT_W * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if ((2 ** BIN_W) < (10 ** NDIG)) begin : g_bad_width
        $error("bcd_to_bin_serial: BIN_W too small for NDIG digits");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    state_t                 state_q, state_d;
    logic [BCD_W-1:0]       bcd_q;
    logic [BIN_W-1:0]       bin_q;
    logic [BIN_W-1:0]       bin_out_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_adj;
    logic                   last_iter;

    assign shifted   = {bcd_q, bin_q} >> 1;
    // cnt reaches BIN_W once all BIN_W iterations are registered.
    assign last_iter = (cnt_q == CNT_W'(BIN_W));

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bin_out   = bin_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q <= bcd_in;
                        bin_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (last_iter) begin
                        bin_out_q <= bin_q;
                    end else begin
                        bcd_q <= bcd_adj;
                        bin_q <= shifted[BIN_W-1:0];
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic any_bad;
    logic err_q;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            any_bad = any_bad | digit_invalid(bcd_in[i*DIGIT_W +: DIGIT_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           err_q <= 1'b0;
        else if (state_q == IDLE && in_valid) err_q <= any_bad;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Self-checking bench for bcd_to_bin_serial: decimal-value model checked
// every cycle, plus directed literal checks (NDIG=2 and NDIG=3 instances).
module tb_bcd_to_bin_serial;

    localparam int NDIG  = 2;
    localparam int BIN_W = 7;
    localparam int N3    = 3;
    localparam int W3    = 10;

`ifdef BCD_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4*NDIG-1:0] bcd_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [BIN_W-1:0] bin_out;
    logic             err;

    logic             in_valid3 = 1'b0;
    logic             in_ready3;
    logic [4*N3-1:0]  bcd_in3 = '0;
    logic             out_valid3;
    logic             out_ready3 = 1'b1;
    logic [W3-1:0]    bin_out3;
    logic             err3;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_bin_serial #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .err(err)
    );

    bcd_to_bin_serial #(.NDIG(N3), .BIN_W(W3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .bcd_in(bcd_in3), .out_valid(out_valid3), .out_ready(out_ready3),
        .bin_out(bin_out3), .err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec_value(input logic [4*NDIG-1:0] b);
        int v = 0;
        for (int i = NDIG-1; i >= 0; i--) v = v*10 + int'(b[i*4 +: 4]);
        return v;
    endfunction

    function automatic bit all_legal(input logic [4*NDIG-1:0] b);
        for (int i = 0; i < NDIG; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Model: phase 0 idle, 1 converting, 2 result presented.
    int   m_phase = 0;
    int   m_age   = 0;
    int   m_val   = 0;
    bit   m_plegal = 1'b1;
    bit   m_perr  = 1'b0;
    int   m_bin   = 0;
    bit   m_known = 1'b1;
    bit   m_err   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_bin   <= 0;
            m_known <= 1'b1;
            m_err   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase  <= 1;
                    m_age    <= 0;
                    m_val    <= dec_value(bcd_in);
                    m_plegal <= all_legal(bcd_in);
                    m_perr   <= CHK && !all_legal(bcd_in);
                end
                1: if (m_age == BIN_W) begin
                    m_phase <= 2;
                    m_bin   <= m_val;
                    m_known <= m_plegal;
                    m_err   <= m_perr;
                end else begin
                    m_age <= m_age + 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, m_phase == 0);
        check("out_valid", out_valid, m_phase == 2);
        if (m_known) check("bin_out", bin_out, m_bin);
        if (m_phase == 2) check("err", err, m_err);
    end

    task automatic wait_result(input int exp_bin, input bit chk_bin, input bit exp_err);
        int lat = 0;
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin got = 1'b1; break; end
        end
        check("result_wait", got, 1'b1);
        check("latency", lat - 1, BIN_W + 1);
        if (chk_bin) check("bin_lit", bin_out, exp_bin);
        check("err_lit", err, exp_err);
    endtask

    task automatic accept(input logic [4*NDIG-1:0] b);
        bit got = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        bcd_in   = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        check("accept_wait", got, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_wait(input logic [4*NDIG-1:0] b, input int exp_bin,
                             input bit chk_bin, input bit exp_err);
        accept(b);
        wait_result(exp_bin, chk_bin, exp_err);
    endtask

    task automatic send3(input logic [4*N3-1:0] b, input int exp_bin);
        bit got = 1'b0;
        int lat = 0;
        @(posedge clk); #1;
        in_valid3 = 1'b1;
        bcd_in3   = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready3) begin got = 1'b1; break; end
        end
        check("accept3_wait", got, 1'b1);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid3) begin got = 1'b1; break; end
        end
        check("result3_wait", got, 1'b1);
        check("latency3", lat - 1, 11);
        check("bin3_lit", bin_out3, exp_bin);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_bin_out", bin_out, 0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;

        // Single conversion with literal result and latency.
        send_wait(8'h10, 10, 1'b1, 1'b0);
        send_wait(8'h00, 0, 1'b1, 1'b0);
        send_wait(8'h99, 99, 1'b1, 1'b0);

        // All legal two-digit inputs, in_valid held high, out_ready tied high.
        out_ready = 1'b1;
        for (int v = 0; v < 100; v++) begin
            bit got = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b1;
            bcd_in   = {4'(v / 10), 4'(v % 10)};
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (in_ready) begin got = 1'b1; break; end
            end
            check("sweep_accept", got, 1'b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(99, 1'b1, 1'b0);

        // Result held under backpressure; new input ignored while busy.
        @(negedge clk);
        out_ready = 1'b0;
        send_wait(8'h37, 37, 1'b1, 1'b0);
        in_valid = 1'b1;
        bcd_in   = 8'h88;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_bin", bin_out, 37);
            check("hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", out_valid, 1'b0);
        check("release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(88, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a conversion.
        accept(8'h55);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_bin_out", bin_out, 0);
        check("midrst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_wait(8'h42, 42, 1'b1, 1'b0);

        // Invalid digit: err only when the check is built in.
        send_wait(8'h1A, 0, 1'b0, CHK);
        send_wait(8'h19, 19, 1'b1, 1'b0);

        // Three-digit instance.
        send3(12'h999, 999);
        send3(12'h000, 0);
        send3(12'h507, 507);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, got 0 expected 1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
